// File: rtl/ex_muldiv_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_e;

    // ALU op field gains one bit so M ops share the execute op bus
    localparam int unsigned ALU_WIDTH_BASE = 4;
    localparam int unsigned ALU_WIDTH      = ALU_WIDTH_BASE + 1;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_signed_div(input md_op_e op);
        return op[2] && !op[0];
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op[2] && op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the multiply/divide datapath: BITS_PER_CYCLE shift-add or
// restoring-subtract steps over a {hi, lo} accumulator.
module ex_muldiv_step
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                  is_div,
    input  logic [2*DWIDTH-1:0]   acc_in,
    input  logic [DWIDTH-1:0]     operand,
    output logic [2*DWIDTH-1:0]   acc_out
);

    logic [2*DWIDTH-1:0] acc;
    logic [DWIDTH:0]     sum;
    logic [DWIDTH:0]     rem_ext;
    logic [DWIDTH+1:0]   diff;

    // multiply: hi += lo[0] ? operand : 0, then shift {carry,hi,lo} right
    // divide:   shift {rem,quo} left, keep rem - operand when it does not borrow
    always_comb begin
        acc     = acc_in;
        sum     = '0;
        rem_ext = '0;
        diff    = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (is_div) begin
                rem_ext = acc[2*DWIDTH-1:DWIDTH-1];
                diff    = {1'b0, rem_ext} - {2'b00, operand};
                if (!diff[DWIDTH+1]) begin
                    acc = {diff[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b1};
                end else begin
                    acc = {rem_ext[DWIDTH-1:0], acc[DWIDTH-2:0], 1'b0};
                end
            end else begin
                sum = {1'b0, acc[2*DWIDTH-1:DWIDTH]}
                    + (acc[0] ? {1'b0, operand} : {(DWIDTH+1){1'b0}});
                acc = {sum, acc[DWIDTH-1:1]};
            end
        end
        acc_out = acc;
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: FSM, iteration
// counter, sign handling and a registered valid/ready result port.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 5,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              ex_clk,
    input  logic              ex_rst,
    input  logic              md_i_valid,
    output logic              md_o_ready,
    input  logic [2:0]        md_i_funct3,
    input  logic [DWIDTH-1:0] md_i_rs1,
    input  logic [DWIDTH-1:0] md_i_rs2,
    input  logic [AWIDTH-1:0] md_i_addr_rd,
    input  logic              md_i_flush,
    output logic              md_o_valid,
    input  logic              md_i_ready,
    output logic [DWIDTH-1:0] md_o_result,
    output logic [AWIDTH-1:0] md_o_addr_rd,
    output logic              md_o_busy
);

    localparam int unsigned N  = DWIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    md_op_e              op_q, op_in;
    logic                neg_a_q, neg_b_q;
    logic [DWIDTH-1:0]   mag_b_q;
    logic [2*DWIDTH-1:0] acc_q, step_acc, prod;
    logic [CW-1:0]       cnt_q;

    logic                accept, last_step;
    logic                signed_a, signed_b, neg_a, neg_b;
    logic                div_zero, div_ovf, special;
    logic [DWIDTH-1:0]   mag_a, mag_b, special_result, fix_result;
    logic [DWIDTH-1:0]   quo, rem;

    logic                valid_d, ready_d, busy_d;
    logic [DWIDTH-1:0]   result_d;
    logic [AWIDTH-1:0]   rd_d;

    // request decode: operand signs, magnitudes and single-cycle special cases
    always_comb begin
        op_in    = md_op_e'(md_i_funct3);
        signed_a = op_is_div(op_in) ? op_is_signed_div(op_in)
                                    : (op_in == MULH || op_in == MULHSU);
        signed_b = op_is_div(op_in) ? op_is_signed_div(op_in) : (op_in == MULH);
        neg_a    = signed_a && md_i_rs1[DWIDTH-1];
        neg_b    = signed_b && md_i_rs2[DWIDTH-1];
        mag_a    = neg_a ? (~md_i_rs1 + DWIDTH'(1)) : md_i_rs1;
        mag_b    = neg_b ? (~md_i_rs2 + DWIDTH'(1)) : md_i_rs2;
        div_zero = op_is_div(op_in) && (md_i_rs2 == '0);
        div_ovf  = op_is_signed_div(op_in) && (md_i_rs1 == MOST_NEG) && (md_i_rs2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_result = op_is_rem(op_in) ? md_i_rs1 : '1;
        end else begin
            special_result = op_is_rem(op_in) ? '0 : md_i_rs1;
        end
    end

    assign accept    = (state_q == S_IDLE) && md_i_valid && !md_i_flush;
    assign last_step = (state_q == S_CALC) && (cnt_q == CW'(N - 1));

    ex_muldiv_step #(
        .DWIDTH         (DWIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div  (op_is_div(op_q)),
        .acc_in  (acc_q),
        .operand (mag_b_q),
        .acc_out (step_acc)
    );

    // sign fix-up applied to the final iteration's accumulator
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (~step_acc + (2*DWIDTH)'(1)) : step_acc;
        quo  = step_acc[DWIDTH-1:0];
        rem  = step_acc[2*DWIDTH-1:DWIDTH];
        case (op_q)
            MUL:                 fix_result = prod[DWIDTH-1:0];
            MULH, MULHSU, MULHU: fix_result = prod[2*DWIDTH-1:DWIDTH];
            DIV, DIVU:           fix_result = (neg_a_q ^ neg_b_q) ? (~quo + DWIDTH'(1)) : quo;
            REM, REMU:           fix_result = neg_a_q ? (~rem + DWIDTH'(1)) : rem;
            default:             fix_result = '0;
        endcase
    end

    always_ff @(posedge ex_clk or negedge ex_rst) begin
        if (!ex_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (md_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (md_i_valid) state_d = special ? S_DONE : S_CALC;
                S_CALC:  if (last_step) state_d = S_DONE;
                S_DONE:  if (md_o_valid && md_i_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d  = (state_d == S_DONE);
        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
        result_d = md_o_result;
        rd_d     = md_o_addr_rd;
        if (accept) begin
            rd_d = md_i_addr_rd;
            if (special) begin
                result_d = special_result;
            end
        end
        if (last_step && !md_i_flush) begin
            result_d = fix_result;
        end
    end

    always_ff @(posedge ex_clk or negedge ex_rst) begin
        if (!ex_rst) begin
            md_o_valid   <= 1'b0;
            md_o_ready   <= 1'b1;
            md_o_busy    <= 1'b0;
            md_o_result  <= '0;
            md_o_addr_rd <= '0;
        end else begin
            md_o_valid   <= valid_d;
            md_o_ready   <= ready_d;
            md_o_busy    <= busy_d;
            md_o_result  <= result_d;
            md_o_addr_rd <= rd_d;
        end
    end

    // operand capture on accept, one iteration per CALC edge
    always_ff @(posedge ex_clk or negedge ex_rst) begin
        if (!ex_rst) begin
            op_q    <= MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mag_b_q <= mag_b;
            acc_q   <= {DWIDTH'(0), mag_a};
            cnt_q   <= '0;
        end else if (state_q == S_CALC) begin
            acc_q   <= step_acc;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the ALU in execute and takes operands already forwarded by execute. Execute holds the pipeline on `md_o_busy`. A registered valid/ready handshake carries the result and `rd` address toward memory/writeback.

## Interface
- `DWIDTH`, 32: operand and result width; must be even.
- `AWIDTH`, 5: register address width.
- `BITS_PER_CYCLE`, 1: quotient/multiplier bits retired per iteration (1, 2 or 4); must divide `DWIDTH`.
- `ex_clk` in 1: clock, rising edge.
- `ex_rst` in 1: reset, asynchronous, active-low.
- `md_i_valid` in 1: request valid.
- `md_o_ready` out 1: unit can accept; high only in IDLE.
- `md_i_funct3` in 3: operation; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `md_i_rs1`, `md_i_rs2` in DWIDTH: operands.
- `md_i_addr_rd` in AWIDTH: destination register.
- `md_i_flush` in 1: abort in-flight operation.
- `md_o_valid` out 1: result valid, registered.
- `md_i_ready` in 1: consumer accepts result.
- `md_o_result` out DWIDTH: result.
- `md_o_addr_rd` out AWIDTH: destination of result.
- `md_o_busy` out 1: high in CALC or DONE; execute stalls on it.

## Operation
- States: IDLE, CALC, DONE. All outputs reset to 0, except `md_o_ready`, which is 1 in reset/IDLE. State resets to IDLE.
- Accept: an operation is accepted in IDLE when `md_i_valid && !md_i_flush`. On accept, latch funct3, rd, operand signs and operand magnitudes, and clear the iteration counter.
- Accept in the special cases below goes straight to DONE. Every other accept goes to CALC.
- Multiply:
  - MULH/MULHSU/MULH use signed rs1, and signed rs2 where the op requires it. MULHU and MUL treat operands as unsigned magnitudes.
  - Algorithm: shift-add over magnitudes into a 2*DWIDTH accumulator.
  - The final product is negated when the operand signs differ.
  - MUL returns the low half; the MULH variants return the high half.
- Divide:
  - Restoring division over magnitudes.
  - Quotient is negated when signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Special cases, result in DONE one edge after accept:
  - Divisor 0: quotient is all ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): quotient = rs1; remainder = 0.
- CALC: retire `BITS_PER_CYCLE` bits per edge for `N = DWIDTH/BITS_PER_CYCLE` edges. Then perform the sign fix-up and move to DONE with `md_o_valid` = 1.
- DONE:
  - Hold `md_o_result`/`md_o_addr_rd` stable while `md_i_ready` = 0.
  - Transfer happens when `md_o_valid && md_i_ready && !md_i_flush`; then return to IDLE and clear valid.
- Flush: in any state, the next edge goes to IDLE with `md_o_valid` = 0, and no result is transferred that cycle. Flush coincident with `md_i_valid` in IDLE means the request is not accepted.
- A new request cannot be accepted in the same cycle a result transfers; the earliest accept is the cycle after.

## Timing
- Normal latency: accept edge, then N CALC edges, then `md_o_valid` high. The result is visible N+1 cycles after the accept edge (33 for DWIDTH=32, BPC=1; 9 for BPC=4).
- Special-case latency: 1 cycle.
- `md_o_busy` rises the cycle after accept and falls the cycle after transfer or flush.
- Reset mid-CALC: all state is cleared immediately (asynchronous), and no result is produced afterwards.
- Iteration counter width is clog2(N)+1; it never wraps within one operation.

## Structure
- Shared header gets new constants: M-extension funct7 (0000001), the funct3 encodings above as `MUL`..`REMU`, and the ALU_WIDTH extension for M ops.
- The state encodings are local to the module.
- One natural sub-module: `ex_muldiv_step`, a combinational single-iteration datapath (`BITS_PER_CYCLE` shift-add/restoring-subtract steps). The top instantiates it once and owns the FSM, counter and sign logic.

## Test plan
- MUL 7 * -3 (0xFFFFFFFD), DWIDTH=32, BPC=1 → result 0xFFFFFFEB; `md_o_valid` exactly 33 cycles after accept; `md_o_ready` low throughout.
- MULH 0x80000000 * 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1 * 2 → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. DIVU 100 / 0 → 0xFFFFFFFF; REMU 100 / 0 → 100. All with valid 1 cycle after accept.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF. Repeat with BPC=4: same values, latency 9.
- Assert flush on CALC cycle 10 → no `md_o_valid`; `md_o_ready` = 1 next cycle; next MULU 3*5 → 15.
- Hold `md_i_ready` low 3 cycles in DONE → result and rd stable; transfer on the 4th cycle. Separately, drop `ex_rst` mid-CALC → all outputs 0 immediately, `md_o_ready` = 1.
